// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath width and the SUB opcode encoding.
package alu_pkg;

  localparam int WIDTH = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/adder_subtracter_4bit.sv
// Four-bit two's-complement adder/subtracter with a combinational result
// and a one-cycle registered copy plus zero and signed-overflow flags.
module adder_subtracter_4bit
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             SUB,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic [WIDTH-1:0] s_q,
  output logic             carry_q,
  output logic             zero_q,
  output logic             ovf_q
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   c;
  logic             zero;
  logic             ovf;

  // Subtraction is a + ~b + 1: invert b and inject SUB as the carry-in.
  assign b_eff = b ^ {WIDTH{SUB}};
  assign c[0]  = SUB;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    full_adder u_fa (
      .a    (a[i]),
      .b    (b_eff[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  // For subtraction carry reads as NOT borrow; overflow when the carries
  // into and out of the sign bit disagree.
  assign carry = c[WIDTH];
  assign ovf   = c[WIDTH-1] ^ c[WIDTH];
  assign zero  = (s == '0);

  // Stage boundary: registered result and flags for the flags register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s_q     <= s;
      carry_q <= carry;
      zero_q  <= zero;
      ovf_q   <= ovf;
    end
  end

endmodule

// File: tb/tb_adder_subtracter_4bit.sv
// Self-checking bench: spec vectors, reset corner cases, exhaustive sweep.
module tb_adder_subtracter_4bit;
  import alu_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] a, b;
  logic             SUB;
  logic [WIDTH-1:0] s, s_q;
  logic             carry, carry_q, zero_q, ovf_q;

  adder_subtracter_4bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .SUB     (SUB),
    .s       (s),
    .carry   (carry),
    .s_q     (s_q),
    .carry_q (carry_q),
    .zero_q  (zero_q),
    .ovf_q   (ovf_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sub;
    logic [3:0] s;
    logic       carry;
    logic       zero;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [3:0] s;
    logic       carry;
    logic       zero;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Independent arithmetic reference using integer math.
  function automatic exp_t model(input logic [3:0] ai, input logic [3:0] bi, input logic si);
    exp_t m;
    int ua = int'(ai);
    int ub = int'(bi);
    int sa = int'($signed(ai));
    int sb = int'($signed(bi));
    int r;
    int sr;
    if (si == OP_ADD) begin
      r = ua + ub;
      m.carry = (r > 15);
      sr = sa + sb;
    end else begin
      r = ua - ub;
      m.carry = (ua >= ub);
      sr = sa - sb;
    end
    m.s    = r[3:0];
    m.zero = (m.s == 4'd0);
    m.ovf  = (sr > 7) || (sr < -8);
    return m;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      n_tests--;
      e = sb_q.pop_front();
      check({tag, " s_q"},     {1'b0, s_q},     {1'b0, e.s});
      check({tag, " carry_q"}, {4'd0, carry_q}, {4'd0, e.carry});
      check({tag, " zero_q"},  {4'd0, zero_q},  {4'd0, e.zero});
      check({tag, " ovf_q"},   {4'd0, ovf_q},   {4'd0, e.ovf});
    end
  endtask

  // Drive between edges, check combinational outputs, then the registered copy.
  task automatic drive(input logic [3:0] ai, input logic [3:0] bi, input logic si,
                       input exp_t e, input string tag);
    @(negedge clk);
    a = ai; b = bi; SUB = si;
    #1;
    check({tag, " s"},     {1'b0, s},     {1'b0, e.s});
    check({tag, " carry"}, {4'd0, carry}, {4'd0, e.carry});
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  task automatic check_q_zero(input string tag);
    check({tag, " s_q"},     {1'b0, s_q},     5'd0);
    check({tag, " carry_q"}, {4'd0, carry_q}, 5'd0);
    check({tag, " zero_q"},  {4'd0, zero_q},  5'd0);
    check({tag, " ovf_q"},   {4'd0, ovf_q},   5'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[12];
    exp_t e;
    string tag;

    vecs[0]  = '{4'h1, 4'h2, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'h3, 4'h1, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'hA, 4'h5, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{4'h8, 4'h1, 1'b1, 4'h7, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{4'h1, 4'h2, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'h5, 4'h5, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{4'h0, 4'h8, 1'b1, 4'h8, 1'b0, 1'b0, 1'b1};

    // Reset asserted with a real falling edge, before any clock edge.
    rst_n = 1'b1; a = 4'h0; b = 4'h0; SUB = OP_ADD;
    #1 rst_n = 1'b0;
    #1 check_q_zero("reset_initial");
    @(posedge clk); #1;
    check_q_zero("reset_held");
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      e.s = vecs[i].s; e.carry = vecs[i].carry; e.zero = vecs[i].zero; e.ovf = vecs[i].ovf;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].a, vecs[i].b, vecs[i].sub, e, tag);
    end

    // Load a nonzero result, then reset mid-cycle between edges.
    e.s = 4'h4; e.carry = 1'b0; e.zero = 1'b0; e.ovf = 1'b0;
    drive(4'h3, 4'h1, OP_ADD, e, "preload");
    #2 rst_n = 1'b0;
    #1 check_q_zero("reset_async");
    a = 4'h9; b = 4'h2; SUB = OP_ADD;
    #1;
    check("reset_track s",     {1'b0, s},     5'h0B);
    check("reset_track carry", {4'd0, carry}, 5'd0);
    @(posedge clk); #1;
    check_q_zero("reset_edge");
    // First edge after release loads the current result.
    @(negedge clk);
    rst_n = 1'b1; a = 4'h2; b = 4'h2; SUB = OP_SUB;
    @(posedge clk); #1;
    check("release s_q",     {1'b0, s_q},     5'd0);
    check("release carry_q", {4'd0, carry_q}, 5'd1);
    check("release zero_q",  {4'd0, zero_q},  5'd1);
    check("release ovf_q",   {4'd0, ovf_q},   5'd0);

    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = i[8:0];
      e = model(v[3:0], v[7:4], v[8]);
      drive(v[3:0], v[7:4], v[8], e, $sformatf("sweep a=%0h b=%0h sub=%0b", v[3:0], v[7:4], v[8]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
